// File: rtl/simon_pkg.sv
// Shared Simon 128/128 constants, FSM state type and round/key helper functions.
package simon_pkg;

  localparam int WORD_W = 64;
  localparam int ROUNDS = 68;
  localparam int CNT_W  = 7;
  localparam int Z_LEN  = 62;
  localparam int Z_W    = 6;

  // Key-schedule constant c = 2^n - 4.
  localparam logic [WORD_W-1:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
  // z2 sequence; bit j is z2[j], so z2[0] is the LSB.
  localparam logic [Z_LEN-1:0]  Z2      = 62'h3369_F885_192C_0EF5;

  localparam logic [CNT_W-1:0]  LAST_RND = 7'd67;
  localparam logic [Z_W-1:0]    Z_LAST   = 6'd61;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_EXPAND  = 4'b0010,
    S_DECRYPT = 4'b0100,
    S_FINISH  = 4'b1000
  } state_t;

  // Round function f(v) = (rol(v,1) & rol(v,8)) ^ rol(v,2).
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
    logic [WORD_W-1:0] rol1;
    logic [WORD_W-1:0] rol2;
    logic [WORD_W-1:0] rol8;
    rol1 = {v[WORD_W-2:0], v[WORD_W-1]};
    rol2 = {v[WORD_W-3:0], v[WORD_W-1:WORD_W-2]};
    rol8 = {v[WORD_W-9:0], v[WORD_W-1:WORD_W-8]};
    return (rol1 & rol8) ^ rol2;
  endfunction

  // Two-word key schedule step: k[i] from k[i-2], k[i-1] and z2 bit.
  function automatic logic [WORD_W-1:0] simon_key_next(input logic [WORD_W-1:0] k_m2,
                                                       input logic [WORD_W-1:0] k_m1,
                                                       input logic              z_bit);
    logic [WORD_W-1:0] ror3;
    logic [WORD_W-1:0] ror4;
    ror3 = {k_m1[2:0], k_m1[WORD_W-1:3]};
    ror4 = {k_m1[3:0], k_m1[WORD_W-1:4]};
    return C_CONST ^ {{(WORD_W-1){1'b0}}, z_bit} ^ k_m2 ^ ror3 ^ ror4;
  endfunction

endpackage

// File: rtl/simon_key_expander.sv
// Simon 128/128 key expander: emits one round key per enabled cycle, starting at k[0].
module simon_key_expander
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [2*WORD_W-1:0] i_key,
  input  logic                i_en,
  output logic [WORD_W-1:0]   o_key
);

  // r_k_m2 / r_k_m1 are the k[i-2] / k[i-1] pair of the next key to be generated;
  // the older word r_k_m2 is the key presented this cycle.
  logic [WORD_W-1:0] r_k_m2;
  logic [WORD_W-1:0] r_k_m1;
  logic [Z_W-1:0]    r_z_idx;

  // Load master key words on start, then slide the window forward one key per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_m2  <= '0;
      r_k_m1  <= '0;
      r_z_idx <= '0;
    end else if (i_load) begin
      r_k_m2  <= i_key[WORD_W-1:0];
      r_k_m1  <= i_key[2*WORD_W-1:WORD_W];
      r_z_idx <= '0;
    end else if (i_en) begin
      r_k_m2  <= r_k_m1;
      r_k_m1  <= simon_key_next(r_k_m2, r_k_m1, Z2[r_z_idx]);
      r_z_idx <= (r_z_idx == Z_LAST) ? 6'd0 : r_z_idx + 6'd1;
    end else begin
      r_k_m2  <= r_k_m2;
      r_k_m1  <= r_k_m1;
      r_z_idx <= r_z_idx;
    end
  end

  assign o_key = r_k_m2;

endmodule

// File: rtl/simon_decrypt_top.sv
// Simon 128/128 decryption core: expands all round keys into a local buffer, then runs
// the inverse rounds reading keys k67..k0.
module simon_decrypt_top
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [2*WORD_W-1:0] ct_i,
  input  logic [2*WORD_W-1:0] k0_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [2*WORD_W-1:0] pt_o
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_round_cnt;
  logic [WORD_W-1:0]  r_x;
  logic [WORD_W-1:0]  r_y;
  logic [WORD_W-1:0]  r_kbuf [0:ROUNDS-1];

  logic               w_accept;
  logic               w_expand;
  logic [WORD_W-1:0]  w_exp_key;
  logic [WORD_W-1:0]  w_round_key;

  assign w_accept    = (r_state == S_IDLE) && start_i;
  assign w_expand    = (r_state == S_EXPAND);
  assign w_round_key = r_kbuf[r_round_cnt];

  simon_key_expander u_key_expander (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_key  (k0_i),
    .i_en   (w_expand),
    .o_key  (w_exp_key)
  );

  // Key buffer fill during EXPAND; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_expand) begin
      r_kbuf[r_round_cnt] <= w_exp_key;
    end
  end

  // Control FSM, x/y datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_round_cnt <= '0;
      r_x         <= '0;
      r_y         <= '0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      pt_o        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_x         <= ct_i[2*WORD_W-1:WORD_W];
            r_y         <= ct_i[WORD_W-1:0];
            r_round_cnt <= 7'd0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b1;
            r_state     <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          if (r_round_cnt == LAST_RND) begin
            // Decryption starts from the last round key.
            r_round_cnt <= LAST_RND;
            r_state     <= S_DECRYPT;
          end else begin
            r_round_cnt <= r_round_cnt + 7'd1;
          end
        end
        S_DECRYPT: begin
          r_x <= r_y;
          r_y <= r_x ^ simon_f(r_y) ^ w_round_key;
          if (r_round_cnt == 7'd0) begin
            r_state <= S_FINISH;
          end else begin
            r_round_cnt <= r_round_cnt - 7'd1;
          end
        end
        S_FINISH: begin
          pt_o    <= {r_x, r_y};
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_decrypt_top.sv
// Self-checking bench for simon_decrypt_top using an independent forward Simon model.
module tb_simon_decrypt_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] ct_i;
  logic [127:0] k0_i;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] pt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simon_decrypt_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .ct_i    (ct_i),
    .k0_i    (k0_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .pt_o    (pt_o)
  );

  // z2 sequence, LSB first, continued past 62 bits.
  localparam logic [63:0] Z2_REF = 64'h7369F885192C0EF5;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  // Reference-style key schedule: k[i+2] = ~k[i] ^ 3 ^ z ^ (I ^ S^-1) S^-3 k[i+1].
  function automatic logic [63:0] ref_key(input logic [127:0] key, input int idx);
    logic [63:0] k [0:67];
    logic [63:0] tmp;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      tmp = rotr(k[i+1], 3);
      tmp = tmp ^ rotr(tmp, 1);
      k[i+2] = ~k[i] ^ tmp ^ {63'd0, Z2_REF[i % 62]} ^ 64'd3;
    end
    return k[idx];
  endfunction

  // Forward encryption model.
  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0] k [0:67];
    logic [63:0] tmp;
    logic [63:0] x;
    logic [63:0] y;
    for (int i = 0; i < 68; i++) k[i] = ref_key(key, i);
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      tmp = x;
      x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full operation; pulse_at >= 0 injects a start pulse with another ct while busy.
  task automatic run_vec(input string name, input logic [127:0] ct, input logic [127:0] key,
                         input logic [127:0] exp_pt, input int pulse_at);
    int   n;
    logic busy_ok;
    @(negedge clk);
    ct_i    = ct;
    k0_i    = key;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ct_i    = ~ct;
    k0_i    = ~key;
    chk({name, " busy at start"}, {127'd0, busy_o}, 128'd1);
    chk({name, " valid cleared"}, {127'd0, valid_o}, 128'd0);
    n = 0;
    busy_ok = 1'b1;
    while (!valid_o && n < 300) begin
      if (n == pulse_at) begin
        start_i = 1'b1;
        ct_i    = 128'h0123456789abcdef_0123456789abcdef;
      end
      @(posedge clk);
      #1;
      n++;
      start_i = 1'b0;
      if (!valid_o && !busy_o) busy_ok = 1'b0;
    end
    chk({name, " latency"}, 128'(n), 128'd137);
    chk({name, " pt"}, pt_o, exp_pt);
    chk({name, " busy held"}, {127'd0, busy_ok}, 128'd1);
    chk({name, " busy low at end"}, {127'd0, busy_o}, 128'd0);
  endtask

  initial begin
    int   n;
    logic stable;
    logic [127:0] rpt;
    logic [127:0] rkey;

    tbl[0].ct  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
    tbl[0].key = 128'h0f0e0d0c0b0a0908_0706050403020100;
    tbl[0].pt  = 128'h63736564207372656c6c657661727420;
    tbl[1].key = 128'd0;
    tbl[1].pt  = 128'd0;
    tbl[2].key = {128{1'b1}};
    tbl[2].pt  = {128{1'b1}};
    tbl[3].key = 128'hdeadbeefcafef00d_0011223344556677;
    tbl[3].pt  = 128'h0123456789abcdef_fedcba9876543210;
    tbl[4].key = 128'h8000000000000000_0000000000000001;
    tbl[4].pt  = 128'h0000000000000001_8000000000000000;
    tbl[5].key = 128'h0000000000000000_ffffffffffffffff;
    tbl[5].pt  = 128'h5555555555555555_aaaaaaaaaaaaaaaa;
    for (int i = 1; i < 6; i++) tbl[i].ct = ref_enc(tbl[i].pt, tbl[i].key);

    chk("model paper vector", ref_enc(tbl[0].pt, tbl[0].key), tbl[0].ct);

    rst_n   = 1'b0;
    start_i = 1'b0;
    ct_i    = 128'd0;
    k0_i    = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {127'd0, busy_o}, 128'd0);
    chk("reset valid", {127'd0, valid_o}, 128'd0);
    chk("reset pt", pt_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: paper vector plus boundary patterns.
    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].ct, tbl[i].key, tbl[i].pt, -1);
    end

    // Loopback with random pt/key pairs through the forward model.
    for (int r = 0; r < 8; r++) begin
      rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_vec($sformatf("rand%0d", r), ref_enc(rpt, rkey), rkey, rpt, -1);
    end

    // Start pulse during DECRYPT cycle 30 must be ignored.
    run_vec("busy ignore", tbl[0].ct, tbl[0].key, tbl[0].pt, 97);

    // Asynchronous reset during EXPAND cycle 40.
    @(negedge clk);
    ct_i    = tbl[0].ct;
    k0_i    = tbl[0].key;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {127'd0, busy_o}, 128'd0);
    chk("midreset valid", {127'd0, valid_o}, 128'd0);
    chk("midreset pt", pt_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after reset", tbl[0].ct, tbl[0].key, tbl[0].pt, -1);

    // Key buffer contents for the paper key.
    chk("kbuf[2]", {64'd0, dut.r_kbuf[2]}, {64'd0, ref_key(tbl[0].key, 2)});
    for (int i = 0; i < 68; i++) begin
      chk($sformatf("kbuf[%0d]", i), {64'd0, dut.r_kbuf[i]}, {64'd0, ref_key(tbl[0].key, i)});
    end

    // Back-to-back: start held high, inputs switched after the first edge.
    @(negedge clk);
    ct_i    = tbl[0].ct;
    k0_i    = tbl[0].key;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    ct_i = tbl[3].ct;
    k0_i = tbl[3].key;
    n = 0;
    while (!valid_o && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b first latency", 128'(n), 128'd137);
    chk("b2b first pt", pt_o, tbl[0].pt);
    @(posedge clk);
    #1;
    chk("b2b restart valid low", {127'd0, valid_o}, 128'd0);
    chk("b2b restart busy", {127'd0, busy_o}, 128'd1);
    chk("b2b restart pt held", pt_o, tbl[0].pt);
    n = 0;
    stable = 1'b1;
    while (!valid_o && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (!valid_o && pt_o !== tbl[0].pt) stable = 1'b0;
    end
    start_i = 1'b0;
    chk("b2b second latency", 128'(n), 128'd137);
    chk("b2b second pt", pt_o, tbl[3].pt);
    chk("b2b first pt stable", {127'd0, stable}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
